fetch_queue_unit: RTL and testbench



---
 rtl/fetch_queue_unit.sv | 124 ++++++++++++
 tb/tb_fetch_queue_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: credit-limited imem requests, in-order instruction
// queue to decode, redirect with discard of in-flight responses, sticky halt.
module fetch_queue_unit #(
  parameter int unsigned     PC_W     = 9,
  parameter int unsigned     INS_W    = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [6:0]      HALT_OPC = 7'b1111111
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [PC_W-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [INS_W-1:0]           imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [PC_W-1:0]            id_pc,
  output logic [INS_W-1:0]           id_instr,
  output logic                       halted,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [PTR_W-1:0] tag_wr, tag_rd;
  logic [PTR_W-1:0] q_wr, q_rd;

  logic [PC_W-1:0]  tag_pc  [DEPTH];
  logic [PC_W-1:0]  q_pc    [DEPTH];
  logic [INS_W-1:0] q_instr [DEPTH];

  logic             credit_ok;
  logic             accept;
  logic             drop;
  logic             tag_pop;
  logic             push;
  logic             pop;
  logic             halt_set;
  logic             flush;
  logic [PC_W-1:0]  head_pc;
  logic [INS_W-1:0] head_instr;

  // Issue credit, response routing and head presentation.
  always_comb begin
    credit_ok      = ({1'b0, outstanding} + {1'b0, occupancy}) < SUM_W'(DEPTH);
    imem_req_valid = !reset && !halted && !redirect_valid && credit_ok;
    imem_req_addr  = pc;
    accept         = imem_req_valid && imem_req_ready;
    drop           = imem_rsp_valid && (drop_cnt != '0);
    tag_pop        = imem_rsp_valid && (drop_cnt == '0);
    push           = tag_pop && !halted;
    head_pc        = q_pc[q_rd];
    head_instr     = q_instr[q_rd];
    id_valid       = (occupancy != '0) && !halted;
    id_pc          = id_valid ? head_pc : '0;
    id_instr       = id_valid ? head_instr : '0;
    pop            = id_valid && id_ready;
    halt_set       = pop && (head_instr[6:0] == HALT_OPC) && !redirect_valid;
    flush          = redirect_valid || halt_set || halted;
  end

  // Control state: PC, credit counters, FIFO pointers, halt flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      occupancy   <= '0;
      halted      <= 1'b0;
    end else begin
      outstanding <= outstanding + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
      halted      <= halted | halt_set;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        pc       <= redirect_pc;
        drop_cnt <= outstanding - CNT_W'(imem_rsp_valid);
        tag_wr   <= '0;
        tag_rd   <= '0;
      end else begin
        if (accept) begin
          pc     <= pc + PC_W'(4);
          tag_wr <= tag_wr + PTR_W'(1);
        end
        if (drop) drop_cnt <= drop_cnt - CNT_W'(1);
        if (tag_pop) tag_rd <= tag_rd + PTR_W'(1);
      end
      if (flush) begin
        q_wr      <= '0;
        q_rd      <= '0;
        occupancy <= '0;
      end else begin
        if (push) q_wr <= q_wr + PTR_W'(1);
        if (pop) q_rd <= q_rd + PTR_W'(1);
        occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Storage: PC tags recorded at issue, instruction queue written on response.
  always_ff @(posedge clk) begin
    if (accept) tag_pc[tag_wr] <= pc;
    if (push && !flush) begin
      q_instr[q_wr] <= imem_rsp_data;
      q_pc[q_wr]    <= tag_pc[tag_rd];
    end
  end

  // A response with nothing outstanding means the memory broke the protocol.
  assert property (@(posedge clk) disable iff (reset) !(imem_rsp_valid && (outstanding == '0)));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: per-cycle vector table for straight-line
// and stall behaviour, hand sequences for latency, redirect, wrap and halt.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [8:0]  imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [8:0]  redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [8:0]  id_pc;
  logic [31:0] id_instr;
  logic        halted;
  logic [2:0]  occupancy;

  fetch_queue_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .halted         (halted),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] addr;
    int         due;
  } pend_t;

  typedef struct {
    logic       id_rdy;
    logic       req_v;
    logic [8:0] req_a;
    logic       id_v;
    logic [8:0] id_pc;
    logic [2:0] occ;
  } vec_t;

  pend_t      pend[$];
  logic [8:0] issued[$];
  logic [8:0] popped[$];
  logic [31:0] popped_ins[$];
  int         cyc;
  int         lat;
  logic       halt_mode;
  int         n_vec;
  int         n_fail;
  vec_t       vt[21];

  function automatic logic [31:0] mem_word(input logic [8:0] a);
    if (halt_mode && a == 9'd8) return 32'h0000_007F;
    return {16'h0, a, 7'h13};
  endfunction

  function automatic logic [31:0] pop_at(input int k);
    return (k < popped.size()) ? 32'(popped[k]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] iss_at(input int k);
    return (k < issued.size()) ? 32'(issued[k]) : 32'hDEAD;
  endfunction

  function automatic vec_t mk(input logic r, input logic rv, input int ra,
                              input logic iv, input int ip, input int oc);
    vec_t v;
    v.id_rdy = r;
    v.req_v  = rv;
    v.req_a  = 9'(ra);
    v.id_v   = iv;
    v.id_pc  = 9'(ip);
    v.occ    = 3'(oc);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // First half of a cycle: memory drives its response, outputs settle.
  task automatic tick_a();
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
      pend.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  // Second half: record handshakes, advance to the next negedge.
  task automatic tick_b();
    pend_t p;
    if (imem_req_valid && imem_req_ready) begin
      p.addr = imem_req_addr;
      p.due  = cyc + lat;
      pend.push_back(p);
      issued.push_back(imem_req_addr);
    end
    if (id_valid && id_ready) begin
      popped.push_back(id_pc);
      popped_ins.push_back(id_instr);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick_a();
      tick_b();
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    halt_mode      = 1'b0;
    lat            = 1;
    pend.delete();
    issued.delete();
    popped.delete();
    popped_ins.delete();
    repeat (2) @(negedge clk);
    #1;
    chk("rst req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst req_addr",  32'(imem_req_addr),  32'd0);
    chk("rst id_valid",  32'(id_valid),       32'd0);
    chk("rst id_pc",     32'(id_pc),          32'd0);
    chk("rst id_instr",  id_instr,            32'd0);
    chk("rst halted",    32'(halted),         32'd0);
    chk("rst occupancy", 32'(occupancy),      32'd0);
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec  = 0;
    n_fail = 0;
    cyc    = 0;

    // Straight-line run, then decode stall with credit exhaustion, then release.
    vt[0]  = mk(1, 1,  0, 0,  0, 0);
    vt[1]  = mk(1, 1,  4, 0,  0, 0);
    vt[2]  = mk(1, 1,  8, 1,  0, 1);
    vt[3]  = mk(1, 1, 12, 1,  4, 1);
    vt[4]  = mk(1, 1, 16, 1,  8, 1);
    vt[5]  = mk(0, 1, 20, 1, 12, 1);
    vt[6]  = mk(0, 1, 24, 1, 12, 2);
    vt[7]  = mk(0, 0, 28, 1, 12, 3);
    for (int i = 8; i < 15; i++) vt[i] = mk(0, 0, 28, 1, 12, 4);
    vt[15] = mk(1, 0, 28, 1, 12, 4);
    vt[16] = mk(1, 1, 28, 1, 16, 3);
    vt[17] = mk(1, 1, 32, 1, 20, 2);
    vt[18] = mk(1, 1, 36, 1, 24, 2);
    vt[19] = mk(1, 1, 40, 1, 28, 2);
    vt[20] = mk(1, 1, 44, 1, 32, 2);

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 21; i++) begin
      id_ready = vt[i].id_rdy;
      tick_a();
      chk($sformatf("v%0d req_valid", i), 32'(imem_req_valid), 32'(vt[i].req_v));
      chk($sformatf("v%0d req_addr", i),  32'(imem_req_addr),  32'(vt[i].req_a));
      chk($sformatf("v%0d id_valid", i),  32'(id_valid),       32'(vt[i].id_v));
      chk($sformatf("v%0d occupancy", i), 32'(occupancy),      32'(vt[i].occ));
      if (vt[i].id_v) begin
        chk($sformatf("v%0d id_pc", i),    32'(id_pc), 32'(vt[i].id_pc));
        chk($sformatf("v%0d id_instr", i), id_instr,   mem_word(vt[i].id_pc));
      end else begin
        chk($sformatf("v%0d id_instr", i), id_instr, 32'd0);
      end
      tick_b();
    end

    // Variable latency with toggling ready: in-order, no loss, credit bounded.
    do_reset();
    lat = 3;
    for (int i = 0; i < 60; i++) begin
      imem_req_ready = (i % 3) != 1;
      id_ready       = (i % 5) != 2;
      tick_a();
      chk("vl credit", 32'((pend.size() + int'(imem_rsp_valid) + int'(occupancy)) <= 4), 32'd1);
      tick_b();
    end
    imem_req_ready = 1'b0;
    id_ready       = 1'b1;
    run(12);
    chk("vl drained count", 32'(popped.size()), 32'(issued.size()));
    chk("vl enough traffic", 32'(popped.size() > 10), 32'd1);
    for (int k = 0; k < popped.size(); k++) begin
      chk($sformatf("vl pc%0d", k),    32'(popped[k]), 32'(9'(4 * k)));
      chk($sformatf("vl instr%0d", k), popped_ins[k],  mem_word(9'(4 * k)));
    end

    // Redirect with two queued entries and two responses in flight.
    do_reset();
    lat = 3;
    run(5);
    redirect_valid = 1'b1;
    redirect_pc    = 9'h040;
    tick_a();
    chk("rd queued before", 32'(occupancy),      32'd2);
    chk("rd no issue",      32'(imem_req_valid), 32'd0);
    tick_b();
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    tick_a();
    chk("rd flushed id_valid", 32'(id_valid),       32'd0);
    chk("rd flushed occ",      32'(occupancy),      32'd0);
    chk("rd new req_valid",    32'(imem_req_valid), 32'd1);
    chk("rd new req_addr",     32'(imem_req_addr),  32'h040);
    tick_b();
    run(20);
    chk("rd first pc",  pop_at(0), 32'h040);
    chk("rd second pc", pop_at(1), 32'h044);
    chk("rd third pc",  pop_at(2), 32'h048);

    // PC wrap through the top of the address space.
    do_reset();
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 9'h1FC;
    tick_a();
    chk("wr no issue", 32'(imem_req_valid), 32'd0);
    tick_b();
    redirect_valid = 1'b0;
    run(10);
    chk("wr iss0", iss_at(0), 32'h1FC);
    chk("wr iss1", iss_at(1), 32'h000);
    chk("wr iss2", iss_at(2), 32'h004);
    chk("wr pop0", pop_at(0), 32'h1FC);
    chk("wr pop1", pop_at(1), 32'h000);
    chk("wr pop2", pop_at(2), 32'h004);

    // Halt opcode popped at PC 8.
    do_reset();
    halt_mode = 1'b1;
    id_ready  = 1'b1;
    run(4);
    tick_a();
    chk("ht head pc",    32'(id_pc),  32'd8);
    chk("ht head instr", id_instr,    32'h7F);
    chk("ht not yet",    32'(halted), 32'd0);
    tick_b();
    tick_a();
    chk("ht halted",    32'(halted),         32'd1);
    chk("ht id_valid",  32'(id_valid),       32'd0);
    chk("ht req_valid", 32'(imem_req_valid), 32'd0);
    chk("ht occupancy", 32'(occupancy),      32'd0);
    tick_b();
    run(6);
    chk("ht no new issues", 32'(issued.size()), 32'd5);
    chk("ht sticky",        32'(halted),        32'd1);
    chk("ht idle id_valid", 32'(id_valid),      32'd0);

    // Halt opcode popped while a redirect is taken: wrong-path, ignored.
    do_reset();
    halt_mode = 1'b1;
    id_ready  = 1'b1;
    run(4);
    redirect_valid = 1'b1;
    redirect_pc    = 9'h080;
    tick_a();
    chk("hr head pc", 32'(id_pc), 32'd8);
    chk("hr head instr", id_instr, 32'h7F);
    tick_b();
    redirect_valid = 1'b0;
    tick_a();
    chk("hr halted",    32'(halted),         32'd0);
    chk("hr id_valid",  32'(id_valid),       32'd0);
    chk("hr req_valid", 32'(imem_req_valid), 32'd1);
    chk("hr req_addr",  32'(imem_req_addr),  32'h080);
    tick_b();
    run(6);
    chk("hr still running", 32'(halted), 32'd0);
    chk("hr first new pc",  pop_at(3),   32'h080);

    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
